movegen_scan: RTL and testbench

Scan sequencer for the 64-square move-generation array. On `start` it pulses the attacker-load phase once, then walks the side-to-move's pieces in ascending square order. For each piece it raises that square's `emit_move`, captures the 64 `target_square` flags returned by the array, and streams the resulting (from, to) pairs out on a valid/ready interface. It is the initiator/collector at the other end of the per-square `emit_move` / `target_square` interface, and sits between the square array and the search/move-list logic.

---
 rtl/movegen_pkg.sv | 30 +++
 rtl/lsb_enc64.sv | 19 +
 rtl/movegen_scan.sv | 151 +++++++++++++++
 tb/tb_movegen_scan.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// Shared types for the move-generation scan sequencer.
// Square index = (rank-1)*8 + (file-1).
package movegen_pkg;

  typedef logic [5:0] sq_t;

  localparam logic [3:0] PC_K = 4'd1;
  localparam logic [3:0] PC_Q = 4'd2;
  localparam logic [3:0] PC_R = 4'd3;
  localparam logic [3:0] PC_B = 4'd4;
  localparam logic [3:0] PC_N = 4'd5;
  localparam logic [3:0] PC_P = 4'd6;
  localparam int PC_COLOR_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_SRC,
    S_EMIT,
    S_OUT,
    S_DONE
  } scan_state_e;

  typedef struct packed {
    sq_t        from;
    sq_t        to;
    logic [2:0] promo;
  } move_t;

endpackage

// File: rtl/lsb_enc64.sv
// Lowest-set-bit encoder for a 64-bit square mask.
// Returns index 0 and any=0 for an empty mask.
module lsb_enc64
  import movegen_pkg::*;
(
  input  logic [63:0] vec,
  output sq_t         idx,
  output logic        any
);

  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) idx = sq_t'(i);
    end
  end

endmodule

// File: rtl/movegen_scan.sv
// Scan sequencer: walks own pieces, strobes emit_move, streams (from,to).
// Define MOVEGEN_PROMO_EN to expand pawn promotions into Q/R/B/N moves.
module movegen_scan
  import movegen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      own_mask,
  input  logic [63:0]      pawn_mask,
  input  logic             wtp,
  output logic             load_attackers,
  output logic [63:0]      emit_move,
  input  logic [63:0]      target_square,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [5:0]       move_from,
  output logic [5:0]       move_to,
  output logic [2:0]       move_promo,
  output logic             busy,
  output logic             scan_done,
  output logic [CNT_W-1:0] move_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  scan_state_e state, state_nxt;

  logic [63:0] src_mask;
  logic [63:0] tgt;
  sq_t         src;
  logic [1:0]  promo_idx;

  sq_t   src_lsb, tgt_lsb;
  logic  src_any, tgt_any;
  logic  fire, is_promo, last_copy;
  move_t mv;

  lsb_enc64 u_src_enc (
    .vec (src_mask),
    .idx (src_lsb),
    .any (src_any)
  );

  lsb_enc64 u_tgt_enc (
    .vec (tgt),
    .idx (tgt_lsb),
    .any (tgt_any)
  );

`ifdef MOVEGEN_PROMO_EN
  logic [63:0] pawn_q;
  logic        wtp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pawn_q <= '0;
      wtp_q  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      pawn_q <= pawn_mask;
      wtp_q  <= wtp;
    end
  end

  // Last rank for the side to move: rank 8 for white, rank 1 for black.
  assign is_promo = pawn_q[src] &&
    (wtp_q ? (&tgt_lsb[5:3]) : (~|tgt_lsb[5:3]));
`else
  logic unused_promo;
  assign unused_promo = ^{pawn_mask, wtp};
  assign is_promo = 1'b0;
`endif

  assign last_copy = !is_promo || (promo_idx == 2'd3);
  assign move_valid = (state == S_OUT) && tgt_any;
  assign fire = move_valid && move_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ATTACK;
      S_ATTACK: state_nxt = S_SRC;
      S_SRC:    state_nxt = src_any ? S_EMIT : S_DONE;
      S_EMIT:   state_nxt = S_OUT;
      S_OUT:    if (!tgt_any) state_nxt = S_SRC;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_mask   <= '0;
      tgt        <= '0;
      src        <= '0;
      promo_idx  <= '0;
      move_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          src_mask   <= own_mask;
          move_count <= '0;
        end
        S_SRC: if (src_any) src <= src_lsb;
        S_EMIT: begin
          tgt       <= target_square;
          promo_idx <= '0;
        end
        S_OUT: begin
          if (!tgt_any) begin
            src_mask[src] <= 1'b0;
          end else if (fire) begin
            if (move_count != CNT_MAX) move_count <= move_count + 1'b1;
            if (last_copy) begin
              tgt[tgt_lsb] <= 1'b0;
              promo_idx    <= '0;
            end else begin
              promo_idx <= promo_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mv = '0;
    if (move_valid) begin
      mv.from  = src;
      mv.to    = tgt_lsb;
      mv.promo = is_promo ? (PC_Q[2:0] + {1'b0, promo_idx}) : 3'd0;
    end
  end

  assign load_attackers = (state == S_ATTACK);
  assign emit_move = (state == S_EMIT) ? (64'd1 << src) : 64'd0;
  assign move_from = mv.from;
  assign move_to = mv.to;
  assign move_promo = mv.promo;
  assign busy = (state != S_IDLE);
  assign scan_done = (state == S_DONE);

endmodule

// File: tb/tb_movegen_scan.sv
// Randomized self-checking bench for movegen_scan with a move-list model.
// The square array is modelled by a per-source target table.
module tb_movegen_scan;

  localparam int CNT_W = 4;
  localparam int CMAX = 15;
`ifdef MOVEGEN_PROMO_EN
  localparam bit PROMO_EN = 1'b1;
`else
  localparam bit PROMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
    logic [2:0] promo;
  } mv_s;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic wtp = 1'b0;
  logic move_ready = 1'b0;
  logic [63:0] own_mask = '0;
  logic [63:0] pawn_mask = '0;
  logic [63:0] target_square;
  logic load_attackers, move_valid, busy, scan_done;
  logic [63:0] emit_move;
  logic [5:0] move_from, move_to;
  logic [2:0] move_promo;
  logic [CNT_W-1:0] move_count;

  movegen_scan #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .own_mask       (own_mask),
    .pawn_mask      (pawn_mask),
    .wtp            (wtp),
    .load_attackers (load_attackers),
    .emit_move      (emit_move),
    .target_square  (target_square),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .move_from      (move_from),
    .move_to        (move_to),
    .move_promo     (move_promo),
    .busy           (busy),
    .scan_done      (scan_done),
    .move_count     (move_count)
  );

  always #5 clk = ~clk;

  logic [63:0] tab [64];
  logic [63:0] noise = '0;

  // Array model: answers the strobed source, garbage otherwise.
  always_comb begin
    target_square = noise;
    for (int i = 0; i < 64; i++) begin
      if (emit_move[i]) target_square = tab[i];
    end
  end

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  mv_s exp_q[$];
  int src_q[$];
  int total;

  // Expected move list straight from the scan rules.
  function automatic void build(input logic [63:0] own,
                                input logic [63:0] pawn,
                                input logic w);
    exp_q.delete();
    src_q.delete();
    for (int s = 0; s < 64; s++) begin
      if (own[s]) begin
        src_q.push_back(s);
        for (int t = 0; t < 64; t++) begin
          if (tab[s][t]) begin
            bit pr;
            pr = PROMO_EN && pawn[s] &&
                 ((w && (t / 8 == 7)) || (!w && (t / 8 == 0)));
            if (pr) begin
              for (int p = 2; p <= 5; p++)
                exp_q.push_back({6'(s), 6'(t), 3'(p)});
            end else begin
              exp_q.push_back({6'(s), 6'(t), 3'd0});
            end
          end
        end
      end
    end
    total = exp_q.size();
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = 0;
  int stall_cnt = 0;
  int e0, off, hs;
  int t_load, t_emit1, t_valid1, t_done, n_load, n_emit;
  bit done_seen, prev_stall, mon_en;
  mv_s cur, prev_mv;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: move_ready = 1'b1;
      1: move_ready = ($urandom % 3) != 0;
      2: move_ready = (stall_cnt >= 5);
      default: move_ready = 1'b0;
    endcase
    noise = {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      off = cyc - e0 + 1;
      cur = {move_from, move_to, move_promo};
      chk("count", 64'(move_count), 64'((hs > CMAX) ? CMAX : hs));
      if (load_attackers) begin
        n_load++;
        t_load = off;
      end
      if (emit_move != 64'd0) begin
        n_emit++;
        if (n_emit == 1) t_emit1 = off;
        if (src_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL emit_extra: got %0h expected none", emit_move);
        end else begin
          chk("emit_src", emit_move, 64'd1 << src_q[0]);
          void'(src_q.pop_front());
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(move_valid), 64'd1);
        chk("stall_hold", 64'(cur), 64'(prev_mv));
      end
      if (move_valid) begin
        if (t_valid1 < 0) t_valid1 = off;
        if (exp_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL move_extra: got %0h expected none", cur);
        end else begin
          chk("move", 64'(cur), 64'(exp_q[0]));
          if (move_ready) begin
            void'(exp_q.pop_front());
            hs++;
          end
        end
        if (mode == 2 && !move_ready) begin
          stall_cnt++;
          chk("stall_count", 64'(move_count), 64'd0);
        end
      end
      prev_stall = move_valid && !move_ready;
      prev_mv = cur;
      if (scan_done) begin
        done_seen = 1'b1;
        t_done = off;
        chk("done_src_left", 64'(src_q.size()), 64'd0);
        chk("done_mv_left", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(move_count),
            64'((total > CMAX) ? CMAX : total));
      end
    end
  end

  task automatic kick(input logic [63:0] own, input logic [63:0] pawn,
                      input logic w, input int md);
    build(own, pawn, w);
    mode = md;
    stall_cnt = 0;
    prev_stall = 1'b0;
    n_load = 0;
    n_emit = 0;
    t_load = -1;
    t_emit1 = -1;
    t_valid1 = -1;
    t_done = -1;
    done_seen = 1'b0;
    @(posedge clk);
    #1;
    own_mask = own;
    pawn_mask = pawn;
    wtp = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    hs = 0;
    own_mask = {$urandom, $urandom};
    pawn_mask = {$urandom, $urandom};
  endtask

  task automatic run_scan(input logic [63:0] own, input logic [63:0] pawn,
                          input logic w, input int md, input bit glitch);
    kick(own, pawn, w, md);
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 2000 && !done_seen; i++) @(negedge clk);
    if (!done_seen) begin
      ncmp++;
      nerr++;
      $display("FAIL scan_timeout: got no scan_done expected done");
    end
    @(negedge clk);
    chk("idle_after", 64'(busy), 64'd0);
    chk("load_once", 64'(n_load), 64'd1);
  endtask

  initial begin
    mon_en = 1'b0;
    hs = 0;
    for (int i = 0; i < 64; i++) tab[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(move_valid), 64'd0);
    chk("rst_emit", emit_move, 64'd0);
    chk("rst_load", 64'(load_attackers), 64'd0);
    chk("rst_count", 64'(move_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // White knight on b1 reaching d2, a3, c3.
    tab[1] = (64'd1 << 11) | (64'd1 << 16) | (64'd1 << 18);
    build(64'd2, 64'd0, 1'b1);
    chk("pin_n_size", 64'(exp_q.size()), 64'd3);
    chk("pin_n_0", 64'(exp_q[0]), {49'd0, 6'd1, 6'd11, 3'd0});
    chk("pin_n_2", 64'(exp_q[2]), {49'd0, 6'd1, 6'd18, 3'd0});
    run_scan(64'd2, 64'd0, 1'b1, 0, 1'b1);
    chk("n_t_load", 64'(t_load), 64'd1);
    chk("n_t_emit", 64'(t_emit1), 64'd3);
    chk("n_t_valid", 64'(t_valid1), 64'd4);
    chk("n_t_done", 64'(t_done), 64'd9);
    chk("n_count", 64'(move_count), 64'd3);

    run_scan(64'd2, 64'd0, 1'b1, 2, 1'b0);
    chk("stall_cycles", 64'(stall_cnt), 64'd5);
    chk("stall_final", 64'(move_count), 64'd3);

    run_scan(64'd0, 64'd0, 1'b1, 0, 1'b0);
    chk("e_t_load", 64'(t_load), 64'd1);
    chk("e_t_done", 64'(t_done), 64'd3);
    chk("e_novalid", 64'(t_valid1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("e_noemit", 64'(n_emit), 64'd0);

    tab[0] = '0;
    tab[63] = 64'h4000_0000_0000_0021;
    run_scan(64'h8000_0000_0000_0001, 64'd0, 1'b1, 1, 1'b0);
    chk("two_emits", 64'(n_emit), 64'd2);
    chk("two_count", 64'(move_count), 64'd3);

    tab[54] = 64'd1 << 62;
    build(64'd1 << 54, 64'd1 << 54, 1'b1);
    chk("pin_promo", 64'(exp_q[0].promo), PROMO_EN ? 64'd2 : 64'd0);
    run_scan(64'd1 << 54, 64'd1 << 54, 1'b1, 0, 1'b0);
    chk("promo_count", 64'(move_count), PROMO_EN ? 64'd4 : 64'd1);

    // Reset while a move is stalled in OUT.
    kick(64'd2, 64'd0, 1'b1, 3);
    for (int i = 0; i < 20 && !move_valid; i++) @(negedge clk);
    chk("pre_rst_valid", 64'(move_valid), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(move_valid), 64'd0);
    chk("mid_rst_out", {move_from, move_to, move_promo}, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    src_q.delete();
    hs = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_count", 64'(move_count), 64'd0);
    mon_en = 1'b1;

    for (int n = 0; n < 25; n++) begin
      logic [63:0] own, pawn;
      for (int s = 0; s < 64; s++)
        tab[s] = {$urandom, $urandom} & {$urandom, $urandom} &
                 {$urandom, $urandom};
      own = {$urandom, $urandom} & {$urandom, $urandom} &
            {$urandom, $urandom} & {$urandom, $urandom};
      pawn = own & {$urandom, $urandom};
      run_scan(own, pawn, 1'($urandom), 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
